control_unit: RTL

//  Hardwired T-state sequencer driving the CPU datapath control strobes.

---
 rtl/cpu_ctrl_pkg.sv | 63 ++++++
 rtl/reg_select_encode.sv | 47 ++++
 rtl/control_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
//   Shared definitions for the hardwired control unit: opcode values,
//   instruction field positions, the T-state encoding and an opcode
//   classifier used by the sequencer's decode.
package cpu_ctrl_pkg;

  localparam int NUM_REGS_DEF = 16;
  localparam int OP_W_DEF     = 5;

  // Instruction field positions within IR
  localparam int OP_LSB = 27;
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    T0      = 4'd1,
    T1      = 4'd2,
    T2      = 4'd3,
    T3      = 4'd4,
    T4      = 4'd5,
    T5      = 4'd6,
    T6      = 4'd7,
    HALTED  = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    C_BINARY,
    C_MULDIV,
    C_UNARY,
    C_NONE,
    C_HALT
  } op_class_t;

  // Execution shape of an opcode; anything unlisted behaves as NOP.
  function automatic op_class_t op_class(input logic [4:0] op);
    op_class_t c;
    c = C_NONE;
    if (op >= OP_ADD && op <= OP_ROL) c = C_BINARY;
    else if (op == OP_MUL || op == OP_DIV) c = C_MULDIV;
    else if (op == OP_NEG || op == OP_NOT) c = C_UNARY;
    else if (op == OP_HALT) c = C_HALT;
    return c;
  endfunction

endpackage

// File: rtl/reg_select_encode.sv
// reg_select_encode
//   Selects one of the IR register fields (Ra/Rb/Rc via gra/grb/grc, Ra has
//   priority) and expands it into one-hot register write/drive enables.
// Ports:
//   ir_ra, ir_rb, ir_rc  in   register fields from IR
//   gra, grb, grc        in   field select
//   rin, rout            in   request write enable / bus drive
//   r_in, r_out          out  one-hot write enable / bus drive (NUM_REGS wide)
module reg_select_encode #(
  parameter int NUM_REGS = 16
) (
  input  logic [3:0]          ir_ra,
  input  logic [3:0]          ir_rb,
  input  logic [3:0]          ir_rc,
  input  logic                gra,
  input  logic                grb,
  input  logic                grc,
  input  logic                rin,
  input  logic                rout,
  output logic [NUM_REGS-1:0] r_in,
  output logic [NUM_REGS-1:0] r_out
);

  logic [3:0] sel;
  logic       any_sel;

  always_comb begin
    sel     = 4'd0;
    any_sel = 1'b0;
    if (gra) begin
      sel     = ir_ra;
      any_sel = 1'b1;
    end else if (grb) begin
      sel     = ir_rb;
      any_sel = 1'b1;
    end else if (grc) begin
      sel     = ir_rc;
      any_sel = 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_onehot
    assign r_in[gi]  = rin  && any_sel && (sel == 4'(gi));
    assign r_out[gi] = rout && any_sel && (sel == 4'(gi));
  end

endmodule

// File: rtl/control_unit.sv
// control_unit
//   Hardwired T-state sequencer: fetch (T0-T2), decode of IR[31:27] and
//   execute of binary ALU, MUL/DIV, unary, NOP and HALT instructions.
//   All strobes are Moore decodes of the current state and IR.
// Ports:
//   Clock, Reset (sync, active-high), IR, Mem_ready
//   fetch strobes: PCout PCin IncPC MARin MDRin MDRout Read IRin
//   result strobes: Yin Zin Zhighout Zlowout HIin LOin HIout LOout
//   R_in / R_out one-hot register enables, ALU_op, Run, State (debug)
// Configuration:
//   CU_MEM_WAIT_EN: T1 stretches until Mem_ready=1; PCin/Zlowout only in
//   the first T1 cycle. Undefined: T1 is one cycle and Mem_ready is ignored.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int OP_W     = OP_W_DEF
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [31:0]         IR,
  input  logic                Mem_ready,
  output logic                PCout,
  output logic                PCin,
  output logic                IncPC,
  output logic                MARin,
  output logic                MDRin,
  output logic                MDRout,
  output logic                Read,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zhighout,
  output logic                Zlowout,
  output logic                HIin,
  output logic                LOin,
  output logic                HIout,
  output logic                LOout,
  output logic [NUM_REGS-1:0] R_in,
  output logic [NUM_REGS-1:0] R_out,
  output logic [OP_W-1:0]     ALU_op,
  output logic                Run,
  output logic [3:0]          State
);

  state_t    state_reg, state_next;
  logic      gra, grb, grc, rin, rout;
  logic [4:0] op;
  op_class_t cls;

  assign op  = IR[OP_LSB +: 5];
  assign cls = op_class(op);

  logic [14:0] ir_unused;
  assign ir_unused = IR[14:0];

  always_ff @(posedge Clock) begin
    if (Reset) state_reg <= S_RESET;
    else       state_reg <= state_next;
  end

`ifdef CU_MEM_WAIT_EN
  // High only on the first cycle of T1 (previous cycle was not T1).
  logic t1_first_reg;
  always_ff @(posedge Clock) begin
    if (Reset) t1_first_reg <= 1'b1;
    else       t1_first_reg <= (state_reg != T1);
  end
`else
  logic mem_ready_unused;
  assign mem_ready_unused = Mem_ready;
`endif

  always_comb begin
    state_next = state_reg;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; Read = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Zin = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
    HIin = 1'b0; LOin = 1'b0; HIout = 1'b0; LOout = 1'b0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; rin = 1'b0; rout = 1'b0;
    ALU_op = '0;
    Run = 1'b1;
    case (state_reg)
      S_RESET: state_next = T0;
      T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        state_next = T1;
      end
      T1: begin
        Read = 1'b1; MDRin = 1'b1;
`ifdef CU_MEM_WAIT_EN
        if (t1_first_reg) begin
          Zlowout = 1'b1; PCin = 1'b1;
        end
        if (Mem_ready) state_next = T2;
`else
        Zlowout = 1'b1; PCin = 1'b1;
        state_next = T2;
`endif
      end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        case (cls)
          C_BINARY, C_MULDIV, C_UNARY: state_next = T3;
          C_HALT:                      state_next = HALTED;
          default:                     state_next = T0;
        endcase
      end
      T3: begin
        grb = 1'b1; rout = 1'b1;
        if (cls == C_UNARY) begin
          ALU_op = OP_W'(op); Zin = 1'b1;
        end else begin
          Yin = 1'b1;
        end
        state_next = T4;
      end
      T4: begin
        if (cls == C_UNARY) begin
          Zlowout = 1'b1; gra = 1'b1; rin = 1'b1;
          state_next = T0;
        end else begin
          grc = 1'b1; rout = 1'b1; ALU_op = OP_W'(op); Zin = 1'b1;
          state_next = T5;
        end
      end
      T5: begin
        Zlowout = 1'b1;
        if (cls == C_MULDIV) begin
          LOin = 1'b1;
          state_next = T6;
        end else begin
          gra = 1'b1; rin = 1'b1;
          state_next = T0;
        end
      end
      T6: begin
        Zhighout = 1'b1; HIin = 1'b1;
        state_next = T0;
      end
      HALTED: Run = 1'b0;
      default: state_next = S_RESET;
    endcase
  end

  assign State = state_reg;

  reg_select_encode #(.NUM_REGS(NUM_REGS)) u_reg_sel (
    .ir_ra (IR[RA_LSB +: 4]),
    .ir_rb (IR[RB_LSB +: 4]),
    .ir_rc (IR[RC_LSB +: 4]),
    .gra   (gra),
    .grb   (grb),
    .grc   (grc),
    .rin   (rin),
    .rout  (rout),
    .r_in  (R_in),
    .r_out (R_out)
  );

endmodule
